alpha_calc_unit: RTL and testbench

- Forward-recursion (alpha) engine for the max-log-MAP SISO decoder of the LTE 8-state RSC code (feedback 1+D^2+D^3, parity 1+D+D^3).
- Consumes one trellis step per cycle: systematic, parity and a-priori LLRs. Emits all 8 alpha metrics of that step as one wide AXI-stream beat, to be written into the alpha RAM.
- Successor to the hard-wired alpha path. Adds parametrised metric width, optional normalisation, saturation, output backpressure and a per-block start/done protocol.

---
 rtl/alpha_calc_unit.sv | 179 +++++++++++++++++
 tb/tb_alpha_calc_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpha_calc_unit.sv
// Forward-recursion (alpha) engine for the max-log-MAP decoder of the LTE 8-state RSC code.
// One trellis step per input beat; emits the pre-update alpha vector of that step per output beat.
module alpha_calc_unit #(
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned MWIDTH     = 16,
    parameter int unsigned BLKLEN_MAX = 6144,
    parameter bit          NORM_EN    = 1'b1
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic                             start,
    input  logic [$clog2(BLKLEN_MAX+1)-1:0]  blklen,
    input  logic [3*DWIDTH-1:0]              s_axis_in_tdata,
    input  logic                             s_axis_in_tvalid,
    output logic                             s_axis_in_tready,
    output logic [8*MWIDTH-1:0]              m_axis_alpha_tdata,
    output logic                             m_axis_alpha_tvalid,
    input  logic                             m_axis_alpha_tready,
    output logic                             m_axis_alpha_tuser,
    output logic                             m_axis_alpha_tlast,
    output logic                             done,
    output logic                             err
);

    localparam int unsigned LW = $clog2(BLKLEN_MAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic signed [MWIDTH-1:0] M_MAX      = {1'b0, {(MWIDTH-1){1'b1}}};
    localparam logic signed [MWIDTH-1:0] M_MIN      = {1'b1, {(MWIDTH-1){1'b0}}};
    localparam logic signed [MWIDTH-1:0] M_INIT_NEG = {2'b11, {(MWIDTH-2){1'b0}}};
    localparam logic [LW-1:0]            BLK_MAX    = LW'(BLKLEN_MAX);
    localparam logic [LW-1:0]            ONE        = LW'(1);

    function automatic logic signed [MWIDTH-1:0] sat_add(input logic signed [MWIDTH-1:0] a,
                                                         input logic signed [MWIDTH-1:0] b);
        logic [MWIDTH:0] sum;
        sum = {a[MWIDTH-1], a} + {b[MWIDTH-1], b};
        if (sum[MWIDTH] != sum[MWIDTH-1]) return sum[MWIDTH] ? M_MIN : M_MAX;
        return sum[MWIDTH-1:0];
    endfunction

    function automatic logic signed [MWIDTH-1:0] sat_sub(input logic signed [MWIDTH-1:0] a,
                                                         input logic signed [MWIDTH-1:0] b);
        logic [MWIDTH:0] dif;
        dif = {a[MWIDTH-1], a} - {b[MWIDTH-1], b};
        if (dif[MWIDTH] != dif[MWIDTH-1]) return dif[MWIDTH] ? M_MIN : M_MAX;
        return dif[MWIDTH-1:0];
    endfunction

    logic [1:0]               state_q, state_d;
    logic [LW-1:0]            blklen_q, k_q;
    logic signed [MWIDTH-1:0] alpha_q [8];
    logic signed [MWIDTH-1:0] alpha_raw [8];
    logic signed [MWIDTH-1:0] alpha_nxt [8];
    logic [8*MWIDTH-1:0]      out_data_q, out_pack;
    logic                     out_valid_q, out_user_q, out_last_q;
    logic                     done_q, done_d, err_q, err_d;

    logic signed [DWIDTH-1:0] l_sys, l_par, l_a;
    logic signed [MWIDTH-1:0] gamma_u, gamma, cand;
    logic [2:0]               st, nst;
    logic                     bit_u, bit_a, bit_p;
    logic                     in_hs, out_hs, last_step, blklen_ok, start_ok;

    assign l_sys = s_axis_in_tdata[DWIDTH-1:0];
    assign l_par = s_axis_in_tdata[2*DWIDTH-1:DWIDTH];
    assign l_a   = s_axis_in_tdata[3*DWIDTH-1:2*DWIDTH];

    assign s_axis_in_tready = (state_q == ST_RUN) && (!out_valid_q || m_axis_alpha_tready);
    assign in_hs            = s_axis_in_tvalid && s_axis_in_tready;
    assign out_hs           = out_valid_q && m_axis_alpha_tready;
    assign last_step        = (k_q == blklen_q - ONE);
    assign blklen_ok        = (blklen != '0) && (blklen <= BLK_MAX);
    assign start_ok         = (state_q == ST_IDLE) && start && blklen_ok;

    // Add-compare-select over all 16 (state, input bit) branches, then optional normalisation.
    always_comb begin
        gamma_u = sat_add(MWIDTH'(l_sys), MWIDTH'(l_a));
        gamma   = '0;
        cand    = '0;
        st      = '0;
        nst     = '0;
        bit_u   = 1'b0;
        bit_a   = 1'b0;
        bit_p   = 1'b0;
        for (int i = 0; i < 8; i++) alpha_raw[i] = M_MIN;
        for (int s = 0; s < 8; s++) begin
            for (int u = 0; u < 2; u++) begin
                st    = 3'(s);
                bit_u = (u == 1);
                bit_a = bit_u ^ st[1] ^ st[0];
                bit_p = bit_a ^ st[2] ^ st[0];
                nst   = {bit_a, st[2], st[1]};
                gamma = sat_add(bit_u ? gamma_u : '0, bit_p ? MWIDTH'(l_par) : '0);
                cand  = sat_add(alpha_q[st], gamma);
                if (cand > alpha_raw[nst]) alpha_raw[nst] = cand;
            end
        end
        for (int i = 0; i < 8; i++) begin
            alpha_nxt[i] = NORM_EN ? sat_sub(alpha_raw[i], alpha_raw[0]) : alpha_raw[i];
        end
    end

    always_comb begin
        out_pack = '0;
        for (int i = 0; i < 8; i++) out_pack[i*MWIDTH +: MWIDTH] = alpha_q[i];
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (blklen_ok) state_d = ST_RUN;
                    else           err_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (in_hs && last_step) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (out_hs) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            blklen_q    <= '0;
            k_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_user_q  <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 8; i++) alpha_q[i] <= (i == 0) ? '0 : M_INIT_NEG;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (start_ok) begin
                blklen_q <= blklen;
                k_q      <= '0;
                for (int i = 0; i < 8; i++) alpha_q[i] <= (i == 0) ? '0 : M_INIT_NEG;
            end else if (in_hs) begin
                k_q <= last_step ? '0 : k_q + ONE;
                for (int i = 0; i < 8; i++) alpha_q[i] <= alpha_nxt[i];
            end
            // The beat carries alpha_k, i.e. the metrics before this step's update.
            if (in_hs) begin
                out_data_q  <= out_pack;
                out_valid_q <= 1'b1;
                out_user_q  <= (k_q == '0);
                out_last_q  <= last_step;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_alpha_tdata  = out_data_q;
    assign m_axis_alpha_tvalid = out_valid_q;
    assign m_axis_alpha_tuser  = out_user_q;
    assign m_axis_alpha_tlast  = out_last_q;
    assign done                = done_q;
    assign err                 = err_q;

endmodule

// File: tb/tb_alpha_calc_unit.sv
// Scoreboard bench for alpha_calc_unit: driver pushes reference beats, monitor pops on acceptance.
module tb_alpha_calc_unit;

    localparam int DW   = 16;
    localparam int MW   = 16;
    localparam int BMAX = 6144;
    localparam int LW   = 13;
    localparam int MAXV = 32767;
    localparam int MINV = -32768;

    logic              aclk, areset, start;
    logic [LW-1:0]     blklen;
    logic [3*DW-1:0]   s_data;
    logic              s_valid, s_ready;
    logic [8*MW-1:0]   m_data;
    logic              m_valid, m_ready, m_user, m_last;
    logic              done, err;

    alpha_calc_unit #(
        .DWIDTH(DW), .MWIDTH(MW), .BLKLEN_MAX(BMAX), .NORM_EN(1'b1)
    ) dut (
        .aclk(aclk), .areset(areset), .start(start), .blklen(blklen),
        .s_axis_in_tdata(s_data), .s_axis_in_tvalid(s_valid), .s_axis_in_tready(s_ready),
        .m_axis_alpha_tdata(m_data), .m_axis_alpha_tvalid(m_valid),
        .m_axis_alpha_tready(m_ready), .m_axis_alpha_tuser(m_user),
        .m_axis_alpha_tlast(m_last), .done(done), .err(err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [8*MW-1:0] data;
        logic            user;
        logic            last;
    } beat_t;

    beat_t exp_q[$];
    int    tests, fails;
    int    alpha_m[8];
    int    k_m;
    int    stim_sys[64], stim_par[64], stim_a[64];
    int    stall_at;
    bit    stall_done, ready_rand;
    int    beats_total, done_count, err_count;

    task automatic check(input string nm, input logic [8*MW-1:0] act, input logic [8*MW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic void model_reset();
        alpha_m[0] = 0;
        for (int s = 1; s < 8; s++) alpha_m[s] = -(1 << (MW - 2));
        k_m = 0;
    endfunction

    // Reference: push the current metrics as the expected beat, then advance one trellis step.
    function automatic void model_step(input int ls, input int lp, input int la, input int blk);
        beat_t b;
        int    nxt[8];
        bit    have[8];
        int    d1, d2, d3, a, p, ns, g, m, ref0;
        for (int s = 0; s < 8; s++) b.data[s*MW +: MW] = MW'(alpha_m[s]);
        b.user = (k_m == 0);
        b.last = (k_m == blk - 1);
        exp_q.push_back(b);
        k_m = b.last ? 0 : k_m + 1;
        for (int s = 0; s < 8; s++) have[s] = 1'b0;
        for (int s = 0; s < 8; s++) begin
            d1 = (s >> 2) & 1;
            d2 = (s >> 1) & 1;
            d3 = s & 1;
            for (int u = 0; u < 2; u++) begin
                a  = u ^ d2 ^ d3;
                p  = a ^ d1 ^ d3;
                ns = 4 * a + 2 * d1 + d2;
                g  = clamp(u * clamp(ls + la) + p * lp);
                m  = clamp(alpha_m[s] + g);
                if (!have[ns] || m > nxt[ns]) begin
                    nxt[ns]  = m;
                    have[ns] = 1'b1;
                end
            end
        end
        ref0 = nxt[0];
        for (int s = 0; s < 8; s++) alpha_m[s] = clamp(nxt[s] - ref0);
    endfunction

    // Monitor: drives output ready, checks stalls, done timing and pops the scoreboard.
    initial begin
        int              beat_idx;
        bit              pend_done;
        int              stall_left;
        logic [8*MW-1:0] held;
        beat_t           b;
        beat_idx = 0; pend_done = 0; stall_left = 0; held = '0;
        m_ready = 1'b0;
        forever begin
            @(negedge aclk);
            if (stall_left == 0 && m_valid && stall_at == beat_idx && !stall_done) begin
                stall_left = 5;
                stall_done = 1'b1;
                held       = m_data;
            end
            if (stall_left > 0) m_ready = 1'b0;
            else                m_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (areset) begin
                beat_idx = 0; pend_done = 0; stall_left = 0;
                m_ready = 1'b0;
                continue;
            end
            if (pend_done || done) check("done_pulse", done, pend_done);
            pend_done = 0;
            if (done) done_count++;
            if (err) err_count++;
            if (stall_left > 0) begin
                check("stall_in_tready", s_ready, 0);
                check("stall_tdata_hold", m_data, held);
                stall_left--;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %h, expected no beat", m_data);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_tdata", m_data, b.data);
                    check("beat_tuser", m_user, b.user);
                    check("beat_tlast", m_last, b.last);
                end
                beats_total++;
                pend_done = m_last;
                beat_idx  = m_last ? 0 : beat_idx + 1;
            end
        end
    end

    task automatic pulse_start(input logic [LW-1:0] len);
        @(negedge aclk);
        start  = 1'b1;
        blklen = len;
        @(negedge aclk);
        start  = 1'b0;
    endtask

    task automatic feed(input int n_feed, input int blk, input bit gaps, input bit inject);
        int i, cyc;
        bit injected;
        i = 0; cyc = 0; injected = 0;
        while (i < n_feed && cyc < 2000) begin
            @(negedge aclk);
            start = 1'b0;
            if (inject && i == 2 && !injected) begin
                start    = 1'b1;
                blklen   = LW'(3);
                injected = 1'b1;
            end
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = {DW'(stim_a[i]), DW'(stim_par[i]), DW'(stim_sys[i])};
            #2;
            if (s_valid && s_ready) begin
                model_step(stim_sys[i], stim_par[i], stim_a[i], blk);
                i++;
            end
            cyc++;
        end
        if (i < n_feed) begin
            tests++;
            fails++;
            $display("FAIL feed_timeout: got %0d steps, expected %0d", i, n_feed);
        end
        @(negedge aclk);
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic run_block(input int n, input bit gaps, input bit inject);
        int b0, d0, e0, cyc;
        b0 = beats_total; d0 = done_count; e0 = err_count;
        model_reset();
        pulse_start(LW'(n));
        feed(n, n, gaps, inject);
        cyc = 0;
        while (done_count == d0 && cyc < 300) begin
            @(negedge aclk);
            #3;
            cyc++;
        end
        repeat (3) @(negedge aclk);
        #3;
        check("done_count", done_count - d0, 1);
        check("beats_per_block", beats_total - b0, n);
        check("scoreboard_empty", exp_q.size(), 0);
        if (inject) check("no_err_in_run", err_count - e0, 0);
    endtask

    task automatic illegal_start(input logic [LW-1:0] len);
        int b0, e0;
        b0 = beats_total; e0 = err_count;
        pulse_start(len);
        #2;
        check("err_pulse", err, 1);
        check("idle_in_tready", s_ready, 0);
        @(negedge aclk);
        #2;
        check("err_one_cycle", err, 0);
        repeat (5) @(negedge aclk);
        #2;
        check("no_beats_after_err", beats_total - b0, 0);
        check("err_count", err_count - e0, 1);
    endtask

    task automatic fill_random(input int n, input bit full);
        for (int i = 0; i < n; i++) begin
            if (full) begin
                stim_sys[i] = int'($signed(16'($urandom)));
                stim_par[i] = int'($signed(16'($urandom)));
                stim_a[i]   = int'($signed(16'($urandom)));
            end else begin
                stim_sys[i] = int'($urandom_range(0, 2000)) - 1000;
                stim_par[i] = int'($urandom_range(0, 2000)) - 1000;
                stim_a[i]   = int'($urandom_range(0, 600)) - 300;
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        beats_total = 0; done_count = 0; err_count = 0;
        stall_at = -1; stall_done = 1'b0; ready_rand = 1'b0;
        areset = 1'b1; start = 1'b0; blklen = '0; s_valid = 1'b0; s_data = '0;
        model_reset();

        repeat (3) @(negedge aclk);
        #2;
        check("rst_tvalid", m_valid, 0);
        check("rst_tdata", m_data, 0);
        check("rst_tuser", m_user, 0);
        check("rst_tlast", m_last, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_in_tready", s_ready, 0);
        @(negedge aclk);
        areset = 1'b0;

        // Single-step block of zeros: the beat is the init vector.
        stim_sys[0] = 0; stim_par[0] = 0; stim_a[0] = 0;
        run_block(1, 1'b0, 1'b0);

        // Directed first step, then a random one.
        fill_random(2, 1'b0);
        stim_sys[0] = 10; stim_par[0] = 4; stim_a[0] = 0;
        run_block(2, 1'b0, 1'b0);

        // 16 random steps with a 5-cycle output stall on beat 6.
        fill_random(16, 1'b0);
        stall_at = 6; stall_done = 1'b0;
        run_block(16, 1'b1, 1'b0);
        check("stall_exercised", stall_done, 1);
        stall_at = -1;

        illegal_start(LW'(0));
        illegal_start(LW'(BMAX + 1));

        // start pulsed mid-block must be ignored.
        ready_rand = 1'b1;
        fill_random(8, 1'b0);
        run_block(8, 1'b1, 1'b1);

        // Saturation corner.
        for (int i = 0; i < 4; i++) begin
            stim_sys[i] = MAXV; stim_par[i] = MAXV; stim_a[i] = MAXV;
        end
        run_block(4, 1'b0, 1'b0);

        // Reset while k=3 of an 8-step block.
        ready_rand = 1'b0;
        fill_random(8, 1'b0);
        model_reset();
        pulse_start(LW'(8));
        feed(3, 8, 1'b0, 1'b0);
        areset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_tvalid", m_valid, 0);
        check("midrst_in_tready", s_ready, 0);
        check("midrst_tlast", m_last, 0);
        @(negedge aclk);
        areset = 1'b0;
        fill_random(4, 1'b0);
        run_block(4, 1'b0, 1'b0);

        // Full-range random blocks under random backpressure.
        ready_rand = 1'b1;
        for (int r = 0; r < 3; r++) begin
            fill_random(12, 1'b1);
            run_block(12, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end, expected $finish");
        $fatal(1, "timeout");
    end

endmodule
